mb_crc3_tx: RTL and testbench
=============================

# mb_crc3_tx

CRC-3 serial transmitter: captures a parallel data word, shifts it out MSB first, then appends the 3-bit CRC for G(x) = x^3 + x + 1. It sits directly upstream of the CRC-3 checker on the serial link. Serial_Out feeds the checker's Serial_In and Select feeds the checker's Select, so a clean frame leaves the checker's remainder at zero (ERROR low) at frame end.

## Interface
- DATA_W, 8, payload bits per frame (≥ 1)
- GCLK  input  1  system clock, rising edge
- CLEAR_bar  input  1  asynchronous active-low reset
- Load  input  1  start-frame request, sampled at the rising edge of GCLK
- Data_In  input  DATA_W  payload, captured on an accepted Load
- Ready  output  1  high when a Load will be accepted this cycle
- Serial_Out  output  1  serial bit stream (registered)
- Select  output  1  high during payload bits, low during CRC bits and idle (registered)
- Busy  output  1  high while a frame is on the line
- Done  output  1  one-cycle pulse coinciding with the last CRC bit
- Inject_Err  input  1  present only with MB_CRC3_TX_INJECT_EN (see Configuration)

## Operation
- States: IDLE, DATA, CRC. Down-counter width is $clog2(DATA_W+1).
- IDLE: Serial_Out=0, Select=0, Busy=0, Done=0, Ready=1.
- Load accepted (Ready=1 at the edge):
  - Data_In goes into the shift register.
  - LFSR clears to 000.
  - State goes to DATA.
- DATA, one bit per cycle, MSB first:
  - Serial_Out = current data bit, Select=1.
  - Feedback f = bit ^ Q2.
  - LFSR update: Q0<=f, Q1<=Q0^f, Q2<=Q1.
  - After DATA_W bits, state goes to CRC.
- CRC, 3 cycles:
  - Serial_Out = Q2, Select=0.
  - LFSR update: Q0<=0, Q1<=Q0, Q2<=Q1. This emits the remainder in the order Q2, Q1, Q0.
- Last CRC cycle: Done=1, Ready=1.
  - Load in this cycle: the next frame's first data bit follows with no gap.
  - No Load in this cycle: state goes to IDLE.
- Load when Ready=0 is ignored. The frame in progress is not disturbed and nothing is queued.
- Data_In is don't-care except on the accepting edge.
- Ready = (state==IDLE) | (state==CRC & last CRC bit). Ready is combinational from state only; it does not depend on Load.

## Timing
- Latency: Load accepted at edge k puts the payload MSB on Serial_Out for the cycle after edge k.
- Frame length: DATA_W+3 cycles.
  - Select is high for cycles 1..DATA_W and low for the 3 CRC cycles.
  - Busy is high for all DATA_W+3 cycles.
- Back-to-back frames run continuously at DATA_W+3 cycles per frame.
- Reset values (async, on CLEAR_bar low): state=IDLE, LFSR=000, shift register=0, counter=0, Serial_Out=0, Select=0, Busy=0, Done=0.
- Reset mid-frame: the frame is abandoned immediately. Outputs return to their reset values without waiting for a clock edge. The first Load after CLEAR_bar rises starts a fresh frame.

## Configuration
- MB_CRC3_TX_INJECT_EN defined:
  - The Inject_Err port exists.
  - Its value is captured on an accepted Load.
  - When the captured value is 1, the last CRC bit (Q0 position) is inverted on Serial_Out only; the LFSR is unaffected.
  - The checker then reports ERROR=1 at frame end.
- MB_CRC3_TX_INJECT_EN undefined:
  - The port is absent.
  - The CRC is always emitted unmodified.

## Test plan
- Reset: hold CLEAR_bar low mid-frame (cycle 4 of a 0xFF frame) -> Serial_Out, Select, Busy, Done go to 0 at once. Next Load of 0x02 produces the full correct frame.
- DATA_W=8, Load 0x01 -> Serial_Out = 0000_0001 then 011, Select = 8 ones then 3 zeros, Done on cycle 11. The checker driven in lockstep shows ERROR=0 after cycle 11.
- Load 0x02 -> CRC bits 110. Load 0x00 -> CRC bits 000. Load 0xFF -> CRC bits 011. The checker ends with ERROR=0 in every case.
- Back-to-back: Load 0x01 held high continuously -> frames repeat with no idle gap. Loads pulsed during DATA or CRC (other than the last CRC cycle) are ignored; the frame count matches the number of accepted edges.
- With MB_CRC3_TX_INJECT_EN and Inject_Err=1, Load 0x01 -> CRC bits 010, and the checker ends with ERROR=1. The next frame with Inject_Err=0 -> ERROR=0.
- Randomized check: 200 random payloads and DATA_W ∈ {1,3,8,16}, each compared against a reference mod-G(x) remainder -> zero mismatches.

Source files
------------

// File: rtl/mb_crc3_tx.sv
// CRC-3 serial transmitter for G(x) = x^3 + x + 1. It sends the payload MSB first, then the 3-bit remainder.
// Optional feature: define MB_CRC3_TX_INJECT_EN to add Inject_Err, which corrupts the last CRC bit on the line.
module mb_crc3_tx #(
  parameter int DATA_W = 8
) (
  input  logic              GCLK,
  input  logic              CLEAR_bar,
  input  logic              Load,
  input  logic [DATA_W-1:0] Data_In,
`ifdef MB_CRC3_TX_INJECT_EN
  input  logic              Inject_Err,
`endif
  output logic              Ready,
  output logic              Serial_Out,
  output logic              Select,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

  // The counter also sequences the 3 CRC bits, so it needs at least 2 bits even when DATA_W is tiny.
  localparam int CNT_W = ($clog2(DATA_W + 1) < 2) ? 2 : $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_FIRST = CNT_W'(2);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [2:0]         lfsr, lfsr_nxt;
  logic               ser_nxt, sel_nxt;
  logic               fb;
  logic               accept;
  logic               inj_q;

  assign Busy   = (state != IDLE);
  assign Done   = (state == CRC) && (cnt == '0);
  assign Ready  = (state == IDLE) || Done;
  assign accept = Load && Ready;

`ifdef MB_CRC3_TX_INJECT_EN
  always_ff @(posedge GCLK or negedge CLEAR_bar) begin
    if (!CLEAR_bar)
      inj_q <= 1'b0;
    else if (accept)
      inj_q <= Inject_Err;
  end
`else
  assign inj_q = 1'b0;
`endif

  // The serial and select outputs are precomputed here for the following cycle.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    lfsr_nxt  = lfsr;
    ser_nxt   = 1'b0;
    sel_nxt   = 1'b0;
    fb        = shreg[DATA_W-1] ^ lfsr[2];
    case (state)
      DATA: begin
        lfsr_nxt  = {lfsr[1], lfsr[0] ^ fb, fb};
        shreg_nxt = shreg << 1;
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
          ser_nxt = shreg_nxt[DATA_W-1];
          sel_nxt = 1'b1;
        end else begin
          state_nxt = CRC;
          cnt_nxt   = CRC_FIRST;
          ser_nxt   = lfsr_nxt[2];
        end
      end
      CRC: begin
        lfsr_nxt = {lfsr[1], lfsr[0], 1'b0};
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
          ser_nxt = lfsr_nxt[2] ^ (inj_q && (cnt == CNT_W'(1)));
        end else begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
    // An accepted Load from idle or from the last CRC cycle always starts a fresh frame.
    if (accept) begin
      state_nxt = DATA;
      shreg_nxt = Data_In;
      cnt_nxt   = DATA_LAST;
      lfsr_nxt  = 3'b000;
      ser_nxt   = Data_In[DATA_W-1];
      sel_nxt   = 1'b1;
    end
  end

  always_ff @(posedge GCLK or negedge CLEAR_bar) begin
    if (!CLEAR_bar) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      lfsr       <= 3'b000;
      Serial_Out <= 1'b0;
      Select     <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      lfsr       <= lfsr_nxt;
      Serial_Out <= ser_nxt;
      Select     <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_mb_crc3_tx.sv
// Testbench for mb_crc3_tx. It instantiates four widths (1, 3, 8 and 16) and checks every frame against a mod-G(x) long-division model.
// When MB_CRC3_TX_INJECT_EN is defined, it also exercises the Inject_Err path.
module tb_mb_crc3_tx;

  logic        GCLK = 1'b0;
  logic        CLEAR_bar;
  logic [3:0]  load_v;
  logic [15:0] din;
  logic [3:0]  rdy, ser, sel, bsy, dn;
  int          checks = 0;
  int          failures = 0;

`ifdef MB_CRC3_TX_INJECT_EN
  logic inj_in;
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  always #5 GCLK = ~GCLK;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 8 : 16;
    mb_crc3_tx #(.DATA_W(W)) dut (
      .GCLK      (GCLK),
      .CLEAR_bar (CLEAR_bar),
      .Load      (load_v[g]),
      .Data_In   (din[W-1:0]),
`ifdef MB_CRC3_TX_INJECT_EN
      .Inject_Err(inj_in),
`endif
      .Ready     (rdy[g]),
      .Serial_Out(ser[g]),
      .Select    (sel[g]),
      .Busy      (bsy[g]),
      .Done      (dn[g])
    );
  end

  function automatic int widthOf(int idx);
    case (idx)
      0:       return 1;
      1:       return 3;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  // Polynomial long division of an n-bit word (MSB = highest power) by x^3 + x + 1.
  function automatic logic [2:0] polyRem(logic [31:0] bits, int n);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 3; i--)
      if (v[i]) v = v ^ (32'hB << (i - 3));
    return v[2:0];
  endfunction

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(int idx, logic [15:0] data, bit inj);
    checkOutput("ready_before_load", 32'(rdy[idx]), 32'd1);
    load_v[idx] = 1'b1;
    din         = data;
`ifdef MB_CRC3_TX_INJECT_EN
    inj_in = inj;
`endif
    @(negedge GCLK);
    load_v[idx] = 1'b0;
  endtask

  // Called at the negedge inside cycle 1 of a frame that has already been accepted.
  task automatic runFrame(int idx, int w, logic [15:0] data, bit inj, bit noise,
                          bit has_next, logic [15:0] nd, bit ninj);
    logic [31:0] g_bits, g_sel, g_busy, g_done, g_rdy, dm, e_bits;
    int n;
    bit inj_eff;
    n       = w + 3;
    inj_eff = INJ_ON && inj;
    g_bits = '0; g_sel = '0; g_busy = '0; g_done = '0; g_rdy = '0;
    for (int c = 0; c < n; c++) begin
      g_bits = {g_bits[30:0], ser[idx]};
      g_sel  = {g_sel[30:0],  sel[idx]};
      g_busy = {g_busy[30:0], bsy[idx]};
      g_done = {g_done[30:0], dn[idx]};
      g_rdy  = {g_rdy[30:0],  rdy[idx]};
      if (c == n - 1) begin
        load_v[idx] = has_next;
        din         = nd;
`ifdef MB_CRC3_TX_INJECT_EN
        inj_in = ninj;
`endif
      end else if (noise) begin
        load_v[idx] = 1'($urandom_range(0, 1));
        din         = 16'($urandom);
`ifdef MB_CRC3_TX_INJECT_EN
        inj_in = 1'($urandom_range(0, 1));
`endif
      end else begin
        load_v[idx] = 1'b0;
      end
      @(negedge GCLK);
    end
    load_v[idx] = 1'b0;
    dm     = 32'(data) & ((32'd1 << w) - 1);
    e_bits = (dm << 3) | 32'(polyRem(dm << 3, n) ^ {2'b00, inj_eff});
    checkOutput("frame_bits", g_bits, e_bits);
    checkOutput("select",     g_sel,  ((32'd1 << w) - 1) << 3);
    checkOutput("busy",       g_busy, (32'd1 << n) - 1);
    checkOutput("done",       g_done, 32'd1);
    checkOutput("ready",      g_rdy,  32'd1);
    checkOutput("checker_error", 32'(polyRem(g_bits, n) != 3'b000), 32'(inj_eff));
    if (!INJ_ON) begin
      if (ninj) $display("[TB] note: inject request unused in this build");
    end
  endtask

  task automatic checkIdle(int idx);
    checkOutput("idle_serial", 32'(ser[idx]), 32'd0);
    checkOutput("idle_busy",   32'(bsy[idx]), 32'd0);
    checkOutput("idle_ready",  32'(rdy[idx]), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit chained, nchain;
    int idx;
    logic [15:0] cur, nxt;
    CLEAR_bar = 1'b0;
    load_v    = 4'b0000;
    din       = '0;
`ifdef MB_CRC3_TX_INJECT_EN
    inj_in = 1'b0;
`endif
    repeat (2) @(negedge GCLK);
    checkOutput("rst_serial", 32'(ser), 32'h0);
    checkOutput("rst_select", 32'(sel), 32'h0);
    checkOutput("rst_busy",   32'(bsy), 32'h0);
    checkOutput("rst_done",   32'(dn),  32'h0);
    checkOutput("rst_ready",  32'(rdy), 32'hF);
    CLEAR_bar = 1'b1;
    @(negedge GCLK);

    // A reset asserted in cycle 4 of an 0xFF frame must clear the outputs without waiting for a clock edge.
    applyStimulus(2, 16'h00FF, 1'b0);
    repeat (3) @(negedge GCLK);
    checkOutput("mid_frame_select", 32'(sel[2]), 32'd1);
    #2 CLEAR_bar = 1'b0;
    #1;
    checkOutput("async_rst_serial", 32'(ser[2]), 32'd0);
    checkOutput("async_rst_select", 32'(sel[2]), 32'd0);
    checkOutput("async_rst_busy",   32'(bsy[2]), 32'd0);
    checkOutput("async_rst_done",   32'(dn[2]),  32'd0);
    @(negedge GCLK);
    @(negedge GCLK);
    CLEAR_bar = 1'b1;
    @(negedge GCLK);
    applyStimulus(2, 16'h0002, 1'b0);
    runFrame(2, 8, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Directed payloads, followed by a back-to-back chain of 0x01 frames.
    applyStimulus(2, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(2, 16'h0000, 1'b0);
    runFrame(2, 8, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(2, 16'h00FF, 1'b0);
    runFrame(2, 8, 16'h00FF, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdle(2);
    applyStimulus(2, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdle(2);

    // Loads pulsed while the line is busy must not start extra frames.
    applyStimulus(2, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    checkIdle(2);

`ifdef MB_CRC3_TX_INJECT_EN
    applyStimulus(2, 16'h0001, 1'b1);
    runFrame(2, 8, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0);
    runFrame(2, 8, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdle(2);
`endif

    chained = 1'b0;
    idx     = 0;
    cur     = '0;
    for (int i = 0; i < 200; i++) begin
      if (!chained) begin
        idx = $urandom_range(0, 3);
        cur = 16'($urandom);
        applyStimulus(idx, cur, 1'b0);
      end
      nxt    = 16'($urandom);
      nchain = (i < 199) && ($urandom_range(0, 2) == 0);
      runFrame(idx, widthOf(idx), cur, 1'b0, 1'($urandom_range(0, 1)), nchain, nxt, 1'b0);
      chained = nchain;
      cur     = nxt;
      if (!chained) checkIdle(idx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
